// File: rtl/rvfi_retire_serializer.sv
// rvfi_retire_serializer
// Takes up to NRET RVFI retirement packets per cycle from a multi-retire core,
// packs the valid channels lowest-index first into a show-ahead FIFO and
// presents them one per cycle on a single-channel valid/ready stream.
// Also tracks whether rvfi_order values arrive consecutively.
//
// Ports:
//   clock, reset                 clock; synchronous active-high reset
//   in_valid[NRET]               per-channel retire valid
//   in_order/in_insn/in_rs*_...  per-channel packet fields, channel c at slice c
//   out_valid / out_ready        head packet handshake
//   out_*                        head packet fields (show-ahead)
//   count                        FIFO occupancy
//   overflow                     sticky: a whole input group was dropped
//   order_err                    sticky: a packet carried an unexpected order
module rvfi_retire_serializer #(
  parameter int NRET  = 2,
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NRET-1:0]          in_valid,
  input  logic [64*NRET-1:0]       in_order,
  input  logic [32*NRET-1:0]       in_insn,
  input  logic [5*NRET-1:0]        in_rs1_addr,
  input  logic [5*NRET-1:0]        in_rs2_addr,
  input  logic [XLEN*NRET-1:0]     in_rs1_rdata,
  input  logic [XLEN*NRET-1:0]     in_rs2_rdata,
  input  logic [5*NRET-1:0]        in_rd_addr,
  input  logic [XLEN*NRET-1:0]     in_rd_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_order,
  output logic [31:0]              out_insn,
  output logic [4:0]               out_rs1_addr,
  output logic [4:0]               out_rs2_addr,
  output logic [XLEN-1:0]          out_rs1_rdata,
  output logic [XLEN-1:0]          out_rs2_rdata,
  output logic [4:0]               out_rd_addr,
  output logic [XLEN-1:0]          out_rd_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     order_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = 64 + 32 + 5 + 5 + XLEN + XLEN + 5 + XLEN;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};

  logic [PW-1:0] mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r, wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          overflow_r, order_err_r;
  logic [63:0]   exp_order_r;

  logic [PW-1:0] pkt_s    [NRET];
  logic [AW-1:0] ch_off_s [NRET];
  logic [CW-1:0] n_in_s, free_s;
  logic          accept_s, pop_s, mismatch_s;
  logic [63:0]   last_order_s;

  // Pack each channel, compute its compacted slot offset and check its order
  // against exp_order + k, where k is its rank among the valid channels.
  always_comb begin
    logic [CW-1:0] n_run;
    logic [63:0]   exp_run;
    n_run        = '0;
    exp_run      = exp_order_r;
    mismatch_s   = 1'b0;
    last_order_s = exp_order_r;
    for (int c = 0; c < NRET; c++) begin
      pkt_s[c] = {in_order[c*64 +: 64], in_insn[c*32 +: 32],
                  in_rs1_addr[c*5 +: 5], in_rs2_addr[c*5 +: 5],
                  in_rs1_rdata[c*XLEN +: XLEN], in_rs2_rdata[c*XLEN +: XLEN],
                  in_rd_addr[c*5 +: 5], in_rd_wdata[c*XLEN +: XLEN]};
      ch_off_s[c] = n_run[AW-1:0];
      if (in_valid[c]) begin
        if (in_order[c*64 +: 64] != exp_run) begin
          mismatch_s = 1'b1;
        end else begin
          mismatch_s = mismatch_s;
        end
        last_order_s = in_order[c*64 +: 64];
        exp_run      = exp_run + 64'd1;
        n_run        = n_run + ONE_C;
      end else begin
        n_run = n_run;
      end
    end
    n_in_s = n_run;
  end

  // Admission uses pre-pop occupancy: a same-cycle pop never makes room.
  always_comb begin
    free_s   = DEPTH_C - count_r;
    accept_s = (n_in_s <= free_s);
    pop_s    = (count_r != '0) && out_ready;
  end

  // Pointers, occupancy, sticky flags and the running order expectation.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
      count_r     <= '0;
      overflow_r  <= 1'b0;
      order_err_r <= 1'b0;
      exp_order_r <= 64'd0;
    end else begin
      rd_ptr_r <= pop_s ? rd_ptr_r + {{(AW-1){1'b0}}, 1'b1} : rd_ptr_r;
      wr_ptr_r <= accept_s ? wr_ptr_r + n_in_s[AW-1:0] : wr_ptr_r;
      count_r  <= count_r + (accept_s ? n_in_s : '0) - (pop_s ? ONE_C : '0);
      overflow_r  <= overflow_r | ~accept_s;
      order_err_r <= order_err_r | mismatch_s;
      // Resync on every non-empty group, dropped or not, so one drop does not
      // cascade into a stream of order errors.
      exp_order_r <= (n_in_s != '0) ? last_order_s + 64'd1 : exp_order_r;
    end
  end

  // Packet storage; cleared on reset so the idle head is never X.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (accept_s) begin
      for (int c = 0; c < NRET; c++) begin
        if (in_valid[c]) begin
          mem_r[wr_ptr_r + ch_off_s[c]] <= pkt_s[c];
        end
      end
    end
  end

  assign out_valid = (count_r != '0);
  assign count     = count_r;
  assign overflow  = overflow_r;
  assign order_err = order_err_r;
  assign {out_order, out_insn, out_rs1_addr, out_rs2_addr,
          out_rs1_rdata, out_rs2_rdata, out_rd_addr, out_rd_wdata} = mem_r[rd_ptr_r];

endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// Randomized + directed bench for rvfi_retire_serializer (NRET=2, DEPTH=8).
// A queue-based reference model predicts occupancy, head packet and flags.
module tb_rvfi_retire_serializer;
  localparam int NRET = 2;
  localparam int XLEN = 32;
  localparam int DEPTH = 8;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NRET-1:0]       in_valid;
  logic [64*NRET-1:0]    in_order;
  logic [32*NRET-1:0]    in_insn;
  logic [5*NRET-1:0]     in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [XLEN*NRET-1:0]  in_rs1_rdata, in_rs2_rdata, in_rd_wdata;
  logic                  out_valid, out_ready;
  logic [63:0]           out_order;
  logic [31:0]           out_insn;
  logic [4:0]            out_rs1_addr, out_rs2_addr, out_rd_addr;
  logic [XLEN-1:0]       out_rs1_rdata, out_rs2_rdata, out_rd_wdata;
  logic [3:0]            count;
  logic                  overflow, order_err;

  rvfi_retire_serializer #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_order(in_order),
    .in_insn(in_insn), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_rdata(in_rs1_rdata), .in_rs2_rdata(in_rs2_rdata),
    .in_rd_addr(in_rd_addr), .in_rd_wdata(in_rd_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_order(out_order),
    .out_insn(out_insn), .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr),
    .out_rs1_rdata(out_rs1_rdata), .out_rs2_rdata(out_rs2_rdata),
    .out_rd_addr(out_rd_addr), .out_rd_wdata(out_rd_wdata),
    .count(count), .overflow(overflow), .order_err(order_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] order;
    logic [31:0] insn;
    logic [4:0]  rs1a, rs2a, rda;
    logic [31:0] rs1d, rs2d, rdd;
  } pkt_t;

  pkt_t        q[$];
  bit          ovf_m, err_m;
  logic [63:0] exp_m;
  int          tests_run = 0;
  int          tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic check_outputs();
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check("count", 64'(count), 64'(q.size()));
    check("overflow", 64'(overflow), 64'(ovf_m));
    check("order_err", 64'(order_err), 64'(err_m));
    if (q.size() != 0) begin
      check("out_order", out_order, q[0].order);
      check("out_insn", 64'(out_insn), 64'(q[0].insn));
      check("out_rs1_addr", 64'(out_rs1_addr), 64'(q[0].rs1a));
      check("out_rs2_addr", 64'(out_rs2_addr), 64'(q[0].rs2a));
      check("out_rs1_rdata", 64'(out_rs1_rdata), 64'(q[0].rs1d));
      check("out_rs2_rdata", 64'(out_rs2_rdata), 64'(q[0].rs2d));
      check("out_rd_addr", 64'(out_rd_addr), 64'(q[0].rda));
      check("out_rd_wdata", 64'(out_rd_wdata), 64'(q[0].rdd));
    end
  endtask

  // Called at a negedge: check current outputs, drive one cycle, update model.
  task automatic step(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                      input logic rdy);
    pkt_t        p[2];
    int          n, k;
    bit          pop, acc;
    logic [63:0] last;
    check_outputs();
    for (int c = 0; c < 2; c++) begin
      p[c].order = (c == 0) ? o0 : o1;
      p[c].insn  = $urandom();
      p[c].rs1a  = 5'($urandom()); p[c].rs2a = 5'($urandom()); p[c].rda = 5'($urandom());
      p[c].rs1d  = $urandom(); p[c].rs2d = $urandom(); p[c].rdd = $urandom();
    end
    in_valid = v;          in_order = {o1, o0};
    in_insn = {p[1].insn, p[0].insn};
    in_rs1_addr = {p[1].rs1a, p[0].rs1a}; in_rs2_addr = {p[1].rs2a, p[0].rs2a};
    in_rd_addr = {p[1].rda, p[0].rda};
    in_rs1_rdata = {p[1].rs1d, p[0].rs1d}; in_rs2_rdata = {p[1].rs2d, p[0].rs2d};
    in_rd_wdata = {p[1].rdd, p[0].rdd};
    out_ready = rdy;
    n   = int'(v[0]) + int'(v[1]);
    pop = (q.size() != 0) && rdy;
    acc = n <= DEPTH - q.size();
    k = 0; last = 64'd0;
    for (int c = 0; c < 2; c++) begin
      if (v[c]) begin
        if (p[c].order != exp_m + 64'(k)) err_m = 1'b1;
        last = p[c].order;
        k++;
      end
    end
    if (k > 0) exp_m = last + 64'd1;
    if (!acc) ovf_m = 1'b1;
    else for (int c = 0; c < 2; c++) if (v[c]) q.push_back(p[c]);
    if (pop) void'(q.pop_front());
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 2'b11;
    in_order = {64'd1, 64'd0};
    out_ready = $urandom_range(0, 1) == 1;
    q.delete(); ovf_m = 1'b0; err_m = 1'b0; exp_m = 64'd0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rst_out_order", out_order, 64'd0);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(2'b00, 64'd0, 64'd0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; in_valid = '0; in_order = '0; in_insn = '0; in_rs1_addr = '0;
    in_rs2_addr = '0; in_rd_addr = '0; in_rs1_rdata = '0; in_rs2_rdata = '0;
    in_rd_wdata = '0; out_ready = 1'b0;
    q.delete(); ovf_m = 1'b0; err_m = 1'b0; exp_m = 64'd0;
    @(negedge clock);
    do_reset();

    // Dual retire, drained immediately.
    step(2'b11, 64'd0, 64'd1, 1'b1);
    check("dual_count", 64'(count), 64'd2);
    idle(3);

    // Non-contiguous valid bits compact without holes.
    do_reset();
    step(2'b10, 64'd55, 64'd0, 1'b1);
    step(2'b01, 64'd1, 64'd99, 1'b1);
    idle(3);

    // Fill, overflow, no cascading order error; pop on full with dropped push.
    do_reset();
    for (int g = 0; g < 4; g++) step(2'b11, 64'(2*g), 64'(2*g+1), 1'b0);
    check("full_count", 64'(count), 64'd8);
    step(2'b11, 64'd8, 64'd9, 1'b0);
    step(2'b11, 64'd10, 64'd11, 1'b0);
    check("ovf_count", 64'(count), 64'd8);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_no_err", 64'(order_err), 64'd0);
    step(2'b01, 64'd12, 64'd0, 1'b1);
    check("pop_drop_count", 64'(count), 64'd7);
    idle(9);

    // Order gap sets order_err but the packet is still delivered.
    do_reset();
    step(2'b11, 64'd0, 64'd1, 1'b1);
    step(2'b01, 64'd3, 64'd0, 1'b1);
    check("gap_err", 64'(order_err), 64'd1);
    idle(3);

    // Reset with buffered data.
    do_reset();
    step(2'b11, 64'd0, 64'd1, 1'b0);
    step(2'b11, 64'd2, 64'd3, 1'b0);
    step(2'b01, 64'd4, 64'd0, 1'b0);
    check("pre_rst_count", 64'(count), 64'd5);
    do_reset();
    check("post_rst_count", 64'(count), 64'd0);
    check("post_rst_valid", 64'(out_valid), 64'd0);
    step(2'b01, 64'd0, 64'd0, 1'b1);
    check("post_rst_err", 64'(order_err), 64'd0);
    idle(2);

    // Randomized traffic with occasional order glitches and resets.
    for (int i = 0; i < 800; i++) begin
      logic [1:0]  v;
      logic [63:0] o0, o1;
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        v  = 2'($urandom());
        o0 = exp_m;
        o1 = v[0] ? exp_m + 64'd1 : exp_m;
        if ($urandom_range(0, 59) == 0) o1 = o1 + 64'($urandom_range(1, 3));
        step(v, o0, o1, $urandom_range(0, 9) < 6);
      end
    end
    idle(10);
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/rvfi_retire_serializer.md
Name: rvfi_retire_serializer

Overview:
- Upstream feeder for single-channel RVFI consumers (register, PC and order checkers).
- Accepts up to NRET retirement packets per cycle from a multi-retire core's RVFI bus, compacts them in channel-index order and buffers them in a FIFO.
- Emits one packet per cycle on a single-channel RVFI stream with valid/ready.
- Flags sticky overflow and retirement-order errors for the formal harness to assert on.

Parameters:
- NRET, 2, retirement channels per cycle (1..4)
- XLEN, 32, register width (32 or 64)
- DEPTH, 8, FIFO entries; power of two, DEPTH >= NRET

Ports:
- clock  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  NRET  per-channel retire valid
- in_order  input  64*NRET  per-channel rvfi_order
- in_insn  input  32*NRET  per-channel instruction word
- in_rs1_addr  input  5*NRET  rs1 index
- in_rs2_addr  input  5*NRET  rs2 index
- in_rs1_rdata  input  XLEN*NRET  rs1 read data
- in_rs2_rdata  input  XLEN*NRET  rs2 read data
- in_rd_addr  input  5*NRET  rd index
- in_rd_wdata  input  XLEN*NRET  rd write data
- out_valid  output  1  head packet valid
- out_ready  input  1  consumer accepts head
- out_order, out_insn, out_rs1_addr, out_rs2_addr, out_rs1_rdata, out_rs2_rdata, out_rd_addr, out_rd_wdata  output  64/32/5/5/XLEN/XLEN/5/XLEN  head packet fields
- count  output  $clog2(DEPTH)+1  current occupancy
- overflow  output  1  sticky: an input group was dropped
- order_err  output  1  sticky: retirement order not consecutive

Behaviour:
- Packet layout: {order, insn, rs1_addr, rs2_addr, rs1_rdata, rs2_rdata, rd_addr, rd_wdata}. Stored as one FIFO entry.
- Reset: rd_ptr = wr_ptr = 0; count = 0; overflow = 0; order_err = 0; exp_order = 0; out_valid = 0.
  - Reset mid-operation discards all buffered packets.
  - Input is ignored on the reset cycle.
- Push group:
  - n_in = popcount(in_valid).
  - Valid channels are compacted lowest-index first into slots wr_ptr, wr_ptr+1, ... (mod DEPTH).
  - Non-contiguous valid bits are legal; invalid channels leave no hole.
- Pop: occurs when out_valid && out_ready; rd_ptr advances by 1.
- Capacity:
  - Admission is checked against pre-pop occupancy: a group is accepted iff n_in <= DEPTH - count.
  - A same-cycle pop does not create space for that cycle's push.
  - Otherwise the whole group is dropped (all-or-nothing) and overflow is set; overflow holds until reset.
  - A pop still proceeds on a drop cycle.
- count update: count_next = count + (accepted ? n_in : 0) - pop. Pointers wrap modulo DEPTH.
- Output:
  - Show-ahead FIFO; out_valid = (count != 0); out_* = entry[rd_ptr].
  - A packet pushed at edge N is visible on out_* in cycle N+1 (1-cycle latency). There is no bypass when empty.
  - out_* are don't-care when out_valid = 0, but hold the last head value (no X) after reset: storage is reset to 0.
- Order check:
  - Each valid channel's packet, in compacted order, is compared against the running expectation: packet k expects exp_order + k.
  - Any mismatch sets order_err (sticky).
  - exp_order_next = order of the last valid packet + 1. This applies whether the group was accepted or dropped, so that a drop does not cascade errors.
  - With n_in = 0, exp_order is unchanged.
- Arithmetic: order compare and increment are 64-bit unsigned, with wrap at 2^64 (no error on wrap).
- Stability: out_* and out_valid hold while out_valid && !out_ready.

Test Plan:
- NRET=2, DEPTH=8. After reset, in_valid=2'b11, orders 0,1, out_ready=1 -> next cycle out_valid=1, out_order=0; following cycle out_order=1; count peaks at 2; order_err=0.
- in_valid=2'b10 with order 0 on channel 1, then 2'b01 with order 1 -> compacted into slots 0 and 1; out_order sequence 0,1; no error.
- out_ready=0; push 4 groups of 2 (orders 0..7) -> count=8. A 5th group (orders 8,9) -> dropped, overflow=1, count stays 8. Next group orders 10,11 -> order_err stays 0; it is dropped because the FIFO is still full.
- FIFO full (count=8), out_ready=1, push one packet -> pop happens, push dropped, count=7, overflow=1.
- Orders 0,1 then 3 -> order_err=1 on the cycle after 3 is accepted; packet 3 is still buffered and emitted.
- Reset asserted with count=5 -> next cycle count=0, out_valid=0, overflow=0, order_err=0. A subsequent push of order 0 is accepted without error.
